// File: rtl/cpu_pkg.sv
// Shared definitions for the single-cycle core: memory arbiter state
// encoding and the instruction-register reset value (a NOP).
package cpu_pkg;

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        DECODE = 2'd1,
        DATA   = 2'd2,
        HALT   = 2'd3
    } arb_state_t;

    localparam logic [31:0] RESET_INSTR_DEF = 32'h0000_0013;

endpackage

// File: rtl/mem_arbiter.sv
// Sequences the shared memory port between instruction fetch and the data
// access of the decoded instruction, and tracks halt and retired count.
module mem_arbiter
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_INSTR = RESET_INSTR_DEF,
    parameter int          CNT_W       = 32
) (
    input  logic             clk,
    input  logic             nRST,
    input  logic [31:0]      iaddr,
    input  logic             dren,
    input  logic             dwen,
    input  logic [31:0]      daddr,
    input  logic [31:0]      dstore,
    input  logic             halt,
    output logic [31:0]      instr,
    output logic             iready,
    output logic             dready,
    output logic [31:0]      dload,
    output logic             ram_ren,
    output logic             ram_wen,
    output logic [31:0]      ram_addr,
    output logic [31:0]      ram_store,
    input  logic [31:0]      ram_load,
    input  logic             ram_ready,
    output logic             halted,
    output logic [CNT_W-1:0] retired
);

    arb_state_t        state_q, state_d;
    logic [31:0]       instr_q, instr_d;
    logic [31:0]       dload_q, dload_d;
    logic [CNT_W-1:0]  retired_q, retired_d;
    logic              halted_q, halted_d;

    // Next-state and memory-port decode; strobes complete within the cycle
    // so the PC can advance on the same edge the access finishes.
    always_comb begin
        state_d   = state_q;
        instr_d   = instr_q;
        dload_d   = dload_q;
        halted_d  = halted_q;
        ram_ren   = 1'b0;
        ram_wen   = 1'b0;
        ram_addr  = iaddr;
        ram_store = 32'h0000_0000;
        iready    = 1'b0;
        dready    = 1'b0;
        dload     = dload_q;
        case (state_q)
            FETCH: begin
                ram_ren = 1'b1;
                if (ram_ready) begin
                    instr_d = ram_load;
                    state_d = DECODE;
                end else begin
                    state_d = FETCH;
                end
            end
            DECODE: begin
                // Halt retires immediately and wins over any memory request.
                if (halt) begin
                    iready   = 1'b1;
                    halted_d = 1'b1;
                    state_d  = HALT;
                end else if (dren || dwen) begin
                    state_d = DATA;
                end else begin
                    iready  = 1'b1;
                    state_d = FETCH;
                end
            end
            DATA: begin
                ram_addr  = daddr;
                ram_store = dstore;
                if (dwen) begin
                    ram_wen = 1'b1;
                end else begin
                    ram_ren = 1'b1;
                end
                if (ram_ready) begin
                    dready  = 1'b1;
                    iready  = 1'b1;
                    dload   = ram_load;
                    dload_d = ram_load;
                    state_d = FETCH;
                end else begin
                    state_d = DATA;
                end
            end
            HALT: begin
                halted_d = 1'b1;
                state_d  = HALT;
            end
            default: begin
                state_d = FETCH;
            end
        endcase
        if (iready) begin
            retired_d = retired_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            retired_d = retired_q;
        end
    end

    // State and architectural registers; reset abandons any access in flight.
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state_q   <= FETCH;
            instr_q   <= RESET_INSTR;
            dload_q   <= 32'h0000_0000;
            retired_q <= {CNT_W{1'b0}};
            halted_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            instr_q   <= instr_d;
            dload_q   <= dload_d;
            retired_q <= retired_d;
            halted_q  <= halted_d;
        end
    end

    assign instr   = instr_q;
    assign retired = retired_q;
    assign halted  = halted_q;

endmodule
